// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a serial-command RAM.
// Latency from grant edge to ack: write 3 cycles, read 4 cycles plus R_HOLD cycles.
// Backpressure: requests are only sampled in IDLE; a busy RAM read path stalls reads in R_HOLD.
module ram_arbiter #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [ADDR_SIZE-1:0] wdata0,
  input  logic [ADDR_SIZE-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [ADDR_SIZE-1:0] rdata0,
  output logic [ADDR_SIZE-1:0] rdata1,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    R_HOLD = 3'd3,
    R_ADDR = 3'd4,
    R_CMD  = 3'd5,
    R_CAP  = 3'd6,
    DONE   = 3'd7
  } state_e;

  // Opcodes carried in the top two bits of the RAM command word.
  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_RCMD  = 2'b11;

  state_e                 state_q, state_d;
  logic                   gnt_id_q, gnt_id_d;   // requester owning the current transaction
  logic                   we_q, we_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [ADDR_SIZE-1:0]   wdata_q, wdata_d;
  logic                   prio_q, prio_d;       // requester that wins the next tie
  logic [ADDR_SIZE-1:0]   rdata0_q, rdata0_d;
  logic [ADDR_SIZE-1:0]   rdata1_q, rdata1_d;
  logic                   gnt_sel;

  // Winner of arbitration: a lone request wins outright, a tie goes to the round-robin pointer.
  always_comb begin
    gnt_sel = 1'b0;
    if (req0 && req1) begin
      gnt_sel = prio_q;
    end else if (req1) begin
      gnt_sel = 1'b1;
    end
  end

  // Next-state logic: grant and latch request fields in IDLE, then walk the command sequence.
  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    prio_d   = prio_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_id_d = gnt_sel;
          prio_d   = ~gnt_sel;
          we_d     = gnt_sel ? we1    : we0;
          addr_d   = gnt_sel ? addr1  : addr0;
          wdata_d  = gnt_sel ? wdata1 : wdata0;
          if (gnt_sel ? we1 : we0) begin
            state_d = W_ADDR;
          end else if (ram_tx_valid) begin
            state_d = R_HOLD;
          end else begin
            state_d = R_ADDR;
          end
        end
      end
      W_ADDR: state_d = W_DATA;
      W_DATA: state_d = DONE;
      R_HOLD: begin
        // The RAM is still shifting out an earlier result; wait for it to finish.
        if (!ram_tx_valid) begin
          state_d = R_ADDR;
        end
      end
      R_ADDR: state_d = R_CMD;
      R_CMD:  state_d = R_CAP;
      R_CAP: begin
        // RAM output is registered, so the read data is valid here, one cycle after R_CMD.
        if (gnt_id_q) begin
          rdata1_d = ram_dout;
        end else begin
          rdata0_d = ram_dout;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched-transaction registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_id_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      prio_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      prio_q   <= prio_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs decoded purely from the state register and latched fields, so reset clears them at once.
  always_comb begin
    ram_din      = '0;
    ram_rx_valid = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    busy         = (state_q != IDLE);
    case (state_q)
      W_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {OP_WADDR, addr_q};
      end
      W_DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = {OP_WDATA, wdata_q};
      end
      R_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {OP_RADDR, addr_q};
      end
      R_CMD: begin
        ram_rx_valid = 1'b1;
        ram_din      = {OP_RCMD, {ADDR_SIZE{1'b0}}};
      end
      DONE: begin
        ack0 = ~gnt_id_q;
        ack1 =  gnt_id_q;
      end
      default: ;
    endcase
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8: width of RAM address and data words.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0/req1  input  1  access request per requester.
REQ-005 SHALL have ports we0/we1  input  1  1=write, 0=read.
REQ-006 SHALL have ports addr0/addr1  input  ADDR_SIZE  target address.
REQ-007 SHALL have ports wdata0/wdata1  input  ADDR_SIZE  write data.
REQ-008 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports rdata0/rdata1  output  ADDR_SIZE  read result, valid when the matching ack is high, held until that requester's next read completes.
REQ-010 SHALL have port ram_din  output  ADDR_SIZE+2  command word to RAM: bits[ADDR_SIZE+1:ADDR_SIZE] opcode, low bits payload.
REQ-011 SHALL have port ram_rx_valid  output  1  command strobe to RAM.
REQ-012 SHALL have port ram_dout  input  ADDR_SIZE  RAM read data.
REQ-013 SHALL have port ram_tx_valid  input  1  RAM read result still being serialized.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, W_ADDR, W_DATA, R_HOLD, R_ADDR, R_CMD, R_CAP, DONE; ram_din and ram_rx_valid decoded from the state register and latched request fields only.
REQ-016 SHALL arbitrate only in IDLE: one request -> grant it; both -> round-robin, granting the requester not granted last; pointer after reset favours requester 0.
REQ-017 SHALL latch granted id, we, addr and wdata on the grant edge; later changes to the requester's inputs have no effect on the transaction.
REQ-018 SHALL, on a write grant, go IDLE->W_ADDR->W_DATA->DONE->IDLE.
REQ-019 SHALL, on a read grant, go to R_HOLD if ram_tx_valid=1, else straight to R_ADDR; R_HOLD->R_ADDR the cycle after ram_tx_valid is sampled 0; then R_ADDR->R_CMD->R_CAP->DONE->IDLE.
REQ-020 SHALL drive ram_rx_valid=1 only in W_ADDR, W_DATA, R_ADDR, R_CMD, exactly one cycle each.
REQ-021 SHALL drive ram_din = {2'b00,addr} in W_ADDR, {2'b01,wdata} in W_DATA, {2'b10,addr} in R_ADDR, {2'b11,0} in R_CMD; all zeros otherwise.
REQ-022 SHALL capture ram_dout into rdata of the granted requester at the end of R_CAP (RAM dout is registered, valid the cycle after R_CMD).
REQ-023 SHALL assert ack of the granted requester for exactly the DONE cycle; the other ack stays 0.
REQ-024 SHALL yield latency from grant edge to ack: write 3 cycles, read 4 cycles plus R_HOLD cycles.
REQ-025 SHALL treat a req still high in the IDLE cycle after DONE as a new request, arbitrated per REQ-016 (no starvation: alternates under continuous contention).
REQ-026 SHALL ignore req0/req1 in every state except IDLE; no queuing.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=IDLE, ram_rx_valid=0, ram_din=0, ack0=ack1=0, rdata0=rdata1=0, busy=0, round-robin pointer favouring requester 0.
REQ-028 SHALL abandon any in-flight transaction on reset without ack; first grant after rst_n rises occurs on the first clk edge with a request.

Verification
REQ-029 Write: req0=1, we0=1, addr0=0x12, wdata0=0xA5 -> ram_din=0x012 then 0x1A5 with ram_rx_valid on 2 consecutive cycles, ack0 pulse 3 cycles after grant.
REQ-030 Read-back: then req1=1, we1=0, addr1=0x12 -> ram_din 0x212, 0x300, ack1 4 cycles after grant, rdata1=0xA5.
REQ-031 Contention: req0=req1=1 held continuously -> grants alternate 0,1,0,1; never two consecutive acks to the same requester.
REQ-032 Read hold: ram_tx_valid=1 for 8 cycles at a read grant -> FSM stays R_HOLD, no ram_rx_valid until the cycle after ram_tx_valid falls, then normal read.
REQ-033 Reset mid-op: rst_n low during W_DATA -> ram_rx_valid, ram_din, busy drop to 0 immediately, no ack; after release req1 granted first if only req1 high.
